// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding,
// seven-segment patterns (active-low, bit order a..g from MSB to LSB)
// and the digit decode function.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_PAUSE  = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit to segment pattern; anything outside 0..9 blanks the display.
  function automatic logic [6:0] seg_decode(input logic [3:0] value);
    case (value)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button: 2-FF synchronizer, stability counter that accepts a new
// level only after DB_CYCLES consecutive identical samples, and a single-cycle
// pulse on each accepted 0->1 transition.
module button_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] stable_cnt;

  // Synchronize, then count samples that disagree with the accepted level;
  // any agreeing sample restarts the count, so short glitches never land.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      level      <= 1'b0;
      press      <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DB_CYCLES - 1)) begin
        level      <= sync_2;
        press      <= sync_2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Board-level counter controller: debounced step/toggle and clear buttons,
// manual or auto-run sequencing of a 0..MAX_COUNT counter, registered
// seven-segment decode on HEX4 and status on LEDG.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int TICK_DIV  = 25000000,
  parameter int MAX_COUNT = 7
) (
  input  logic        CLOCK_50,
  input  logic [17:0] SW,
  input  logic [3:0]  V_BT,
  output logic [0:6]  HEX4,
  output logic [1:0]  LEDG
);

  localparam int         PW    = $clog2(TICK_DIV + 1);
  localparam logic [3:0] MAX_C = 4'(MAX_COUNT);

  logic rst;
  logic mode;
  logic dir;
  assign rst  = SW[17];
  assign mode = SW[1];
  assign dir  = SW[0];

  logic step_level, step_press;
  logic clr_level, clr_press;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .clk   (CLOCK_50),
    .rst   (rst),
    .btn   (V_BT[3]),
    .level (step_level),
    .press (step_press)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
    .clk   (CLOCK_50),
    .rst   (rst),
    .btn   (V_BT[2]),
    .level (clr_level),
    .press (clr_press)
  );

  // Switch and button bits with no function on this board are collected here.
  logic unused_ok;
  assign unused_ok = &{1'b0, SW[16:2], V_BT[1:0], step_level, clr_level};

  state_t        state;
  logic [3:0]    count;
  logic [PW-1:0] presc;
  logic [6:0]    seg_q;

  logic       tick;
  logic       advance;
  logic [3:0] count_step;

  // Auto-run tick, step request and the wrapped next count value.
  // NOTE: every always_comb output gets a value on every path, so no latch.
  always_comb begin
    tick       = (state == S_RUN) && (presc == PW'(TICK_DIV - 1));
    advance    = tick || ((state == S_MANUAL) && step_press);
    count_step = count;
    if (dir) count_step = (count == 4'd0) ? MAX_C : count - 4'd1;
    else     count_step = (count == MAX_C) ? 4'd0 : count + 4'd1;
  end

  // Sequencer FSM with counter, prescaler and registered segment decode.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state <= mode ? S_PAUSE : S_MANUAL;
      count <= 4'd0;
      presc <= '0;
      seg_q <= SEG_0;
    end else begin
      seg_q <= seg_decode(count);

      // Clear outranks a coincident step or tick.
      if (clr_press)    count <= 4'd0;
      else if (advance) count <= count_step;

      // The prescaler only runs while staying in S_RUN; a tick wraps it.
      if (clr_press || !mode || state != S_RUN || step_press || tick)
        presc <= '0;
      else
        presc <= presc + PW'(1);

      if (!mode) begin
        state <= S_MANUAL;
      end else begin
        unique case (state)
          S_MANUAL: state <= S_PAUSE;
          S_PAUSE:  if (step_press) state <= S_RUN;
          S_RUN:    if (step_press) state <= S_PAUSE;
          default:  state <= S_PAUSE;
        endcase
      end
    end
  end

  assign HEX4    = seg_q;
  assign LEDG[0] = (state == S_RUN);
  assign LEDG[1] = !rst && (dir ? (count == 4'd0) : (count == MAX_C));

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer with small timing parameters.
// The reference model works in whole presses and elapsed cycles: a press
// moves the count one step modulo MAX_COUNT+1, and auto-run advances
// floor(cycles_in_run / TICK_DIV) steps.
module tb_counter_sequencer;

  localparam int DB = 4;
  localparam int TD = 8;
  localparam int MX = 7;
  // Cycles from the first driven level of a button to the state/count update.
  localparam int LAT = DB + 3;

  logic        clk = 1'b0;
  logic [17:0] sw;
  logic [3:0]  vbt;
  logic [0:6]  hex4;
  logic [1:0]  ledg;

  int errors = 0;
  int checks = 0;
  int model_count = 0;

  counter_sequencer #(
    .DB_CYCLES (DB),
    .TICK_DIV  (TD),
    .MAX_COUNT (MX)
  ) dut (
    .CLOCK_50 (clk),
    .SW       (sw),
    .V_BT     (vbt),
    .HEX4     (hex4),
    .LEDG     (ledg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_ref(input int v);
    case (v)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int step_n(input int c, input bit d, input int n);
    int m;
    m = n % (MX + 1);
    return d ? (c - m + MX + 1) % (MX + 1) : (c + m) % (MX + 1);
  endfunction

  function automatic bit term_ref(input int c, input bit d);
    return d ? (c == 0) : (c == MX);
  endfunction

  // Count seen after edge k of an auto-run window entered at edge 'entry'
  // and paused at edge 'p' (the tick at 'p' itself still counts).
  function automatic int cnt_at(input int start, input bit d, input int entry,
                                input int p, input int k);
    if (k < entry) return start;
    return step_n(start, d, ((k < p ? k : p) - entry) / TD);
  endfunction

  task automatic press(input logic [3:0] mask, input int hold);
    vbt = mask;
    repeat (hold) @(negedge clk);
    vbt = 4'b0000;
    repeat (DB + 6) @(negedge clk);
  endtask

  task automatic check_display(input string name, input bit d, input bit running);
    checks++;
    if (hex4 !== seg_ref(model_count)) begin
      errors++;
      $display("FAIL %s hex: got %b expected %b", name, hex4, seg_ref(model_count));
    end
    checks++;
    if (ledg !== {term_ref(model_count, d), running}) begin
      errors++;
      $display("FAIL %s ledg: got %b expected %b", name, ledg,
               {term_ref(model_count, d), running});
    end
  endtask

  // Starts a toggle press at k=0 from S_PAUSE, optional second toggle at kp,
  // and checks HEX4/LEDG every cycle against the elapsed-time model.
  task automatic run_auto(input int start, input bit d, input int kp, input int total);
    int p, ce, cp;
    p = (kp > 0) ? kp + LAT : total + 1000;
    vbt = 4'b1000;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (k == DB + 4) vbt = 4'b0000;
      if (kp > 0 && k == kp) vbt = 4'b1000;
      if (kp > 0 && k == kp + DB + 4) vbt = 4'b0000;
      ce = cnt_at(start, d, LAT, p, k);
      cp = cnt_at(start, d, LAT, p, k - 1);
      checks++;
      if (hex4 !== seg_ref(cp)) begin
        errors++;
        $display("FAIL auto_hex k=%0d: got %b expected %b", k, hex4, seg_ref(cp));
      end
      checks++;
      if (ledg !== {term_ref(ce, d), (k >= LAT && k < p)}) begin
        errors++;
        $display("FAIL auto_ledg k=%0d: got %b expected %b", k, ledg,
                 {term_ref(ce, d), (k >= LAT && k < p)});
      end
    end
    vbt = 4'b0000;
    model_count = cnt_at(start, d, LAT, p, total);
  endtask

  task automatic test_reset();
    sw  = 18'h20001;
    vbt = 4'b0000;
    repeat (2) begin
      @(negedge clk);
      vbt = 4'($urandom);
    end
    @(negedge clk);
    model_count = 0;
    checks++;
    if (hex4 !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_hex: got %b expected 0000001", hex4);
    end
    checks++;
    if (ledg !== 2'b00) begin
      errors++;
      $display("FAIL reset_ledg: got %b expected 00", ledg);
    end
    vbt = 4'b0000;
    sw  = 18'h00000;
    repeat (DB + 8) @(negedge clk);
    check_display("reset_release", 1'b0, 1'b0);
  endtask

  task automatic test_manual_up();
    sw = 18'h00000;
    for (int i = 0; i < 8; i++) begin
      press(4'b1000, $urandom_range(DB + 1, DB + 6));
      model_count = step_n(model_count, 1'b0, 1);
      check_display("manual_up", 1'b0, 1'b0);
    end
  endtask

  task automatic test_manual_down_glitch();
    bit d;
    sw = 18'h00001;
    repeat (2) @(negedge clk);
    press(4'b1000, DB + 2);
    model_count = step_n(model_count, 1'b1, 1);
    check_display("manual_down", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vbt = 4'b1000;
      repeat ($urandom_range(1, DB - 1)) @(negedge clk);
      vbt = 4'b0000;
      repeat (DB + 3) @(negedge clk);
      check_display("glitch", 1'b1, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      d = 1'($urandom_range(0, 1));
      sw = {16'h0000, 1'b0, d};
      repeat (2) @(negedge clk);
      check_display("dir_change", d, 1'b0);
      press(4'b1000, $urandom_range(DB + 1, DB + 6));
      model_count = step_n(model_count, d, 1);
      check_display("manual_rand", d, 1'b0);
    end
  endtask

  task automatic test_auto_run(input int kp);
    bit d;
    d = 1'($urandom_range(0, 1));
    sw = {16'h0000, 1'b1, d};
    repeat (3) @(negedge clk);
    check_display("auto_pause_entry", d, 1'b0);
    run_auto(model_count, d, kp, kp + LAT + 40);
  endtask

  task automatic test_clear_wins();
    sw = 18'h00000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < MX + 1 && model_count != 3; i++) begin
      press(4'b1000, DB + 2);
      model_count = step_n(model_count, 1'b0, 1);
    end
    check_display("clear_setup", 1'b0, 1'b0);
    press(4'b1100, DB + 2);
    model_count = 0;
    check_display("clear_wins", 1'b0, 1'b0);
  endtask

  task automatic test_reset_midrun();
    sw = 18'h00002;
    repeat (3) @(negedge clk);
    run_auto(model_count, 1'b0, 0, LAT + 5 * TD + 3);
    checks++;
    if (model_count != 5) begin
      errors++;
      $display("FAIL midrun_setup: model count %0d expected 5", model_count);
    end
    sw[17] = 1'b1;
    @(negedge clk);
    model_count = 0;
    checks++;
    if (hex4 !== 7'b0000001 || ledg !== 2'b00) begin
      errors++;
      $display("FAIL midrun_reset: got hex %b ledg %b expected 0000001 00", hex4, ledg);
    end
    sw[17] = 1'b0;
    repeat (3 * TD) @(negedge clk);
    check_display("midrun_paused", 1'b0, 1'b0);
    run_auto(0, 1'b0, 0, LAT + 2 * TD + 2);
  endtask

  initial begin
    sw  = 18'h20001;
    vbt = 4'b0000;
    test_reset();
    test_manual_up();
    test_manual_down_glitch();
    test_auto_run(16);
    test_auto_run(16 + int'($urandom_range(1, 2 * TD)));
    test_clear_wins();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
